conv5x5_multich_stream: RTL
===========================

Name: conv5x5_multich_stream

Overview:
Streaming valid-mode 5x5 convolution engine for the layer-1 path. It computes NUM_CH output channels in parallel from one unsigned pixel stream, using internal line buffers and runtime-loadable weight and bias registers. It adds optional ReLU, shift-and-saturate requantisation, frame/row tracking with start-of-frame resync, and a frame_done pulse. It replaces the single-channel, fixed-weight-port accelerator ahead of the pooling stage.

Parameters:
IMG_WIDTH, 28, pixels per input row (≥5)
IMG_HEIGHT, 28, rows per frame (≥5)
NUM_CH, 4, output channels computed in parallel (1..8)
DATA_WIDTH, 8, unsigned pixel width
WEIGHT_WIDTH, 8, signed weight and bias width
ACC_WIDTH, 24, signed accumulator width (≥ DATA_WIDTH+WEIGHT_WIDTH+6)
OUT_WIDTH, 16, signed output width per channel
OUT_SHIFT, 0, arithmetic right shift applied before saturation
RELU_EN, 1, 1 = clamp negative results to 0

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
valid_in  in  1  pixel_in is valid this cycle
sof_in  in  1  qualified by valid_in; this pixel is (row 0, col 0)
pixel_in  in  DATA_WIDTH  unsigned pixel, raster order
wt_we  in  1  weight/bias write strobe
wt_ch  in  3  target channel (0..NUM_CH-1)
wt_idx  in  5  0..24 = kernel tap row*5+col; 25 = bias
wt_data  in  WEIGHT_WIDTH  signed value to write
wt_err  out  1  one-cycle pulse: write dropped
frame_busy  out  1  high from the first accepted pixel to the last pixel of a frame
result  out  NUM_CH*OUT_WIDTH  channel c in bits [c*OUT_WIDTH +: OUT_WIDTH]
result_valid  out  1  result is valid this cycle
frame_done  out  1  pulses together with the last output of a frame

Behaviour:
- Decided: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset: result=0, result_valid=0, frame_done=0, wt_err=0, frame_busy=0. Row/col counters=0. All weights and biases=0. Line buffer contents are don't-care.
- Position tracking: col/row counters advance only on valid_in. Col wraps at IMG_WIDTH-1 and increments row. After pixel (IMG_HEIGHT-1, IMG_WIDTH-1), both return to 0 and frame_busy drops.
- Resync: valid_in&sof_in forces the pixel to position (0,0) regardless of the counters. A mid-frame resync aborts the current frame. No frame_done is produced for the aborted frame. Outputs already in the pipeline still emerge.
- Window: a 5x5 window ending at (r,c) is complete when r≥4 and c≥4. Output (r-4, c-4) is produced for such pixels only. The output size is (IMG_HEIGHT-4)x(IMG_WIDTH-4), i.e. 24x24 by default.
- Latency: if the completing pixel is accepted in cycle T, result_valid is high in cycle T+3 for one cycle. Pipeline stages are: window registers, 25 products per channel, adder tree plus bias, then ReLU/shift/saturate. Gaps in valid_in never drop or duplicate outputs. There is no backpressure.
- Arithmetic, per channel:
  - acc = Σ zero-extended pixel × signed weight + sign-extended bias, computed in ACC_WIDTH with no overflow for legal parameters.
  - If RELU_EN is set and acc<0, acc=0.
  - acc is then shifted right arithmetically by OUT_SHIFT.
  - The result saturates to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- frame_done is asserted with the result_valid of output (IMG_HEIGHT-5, IMG_WIDTH-5) of a non-aborted frame.
- Weight load: a write takes effect on the next cycle.
  - Writes with wt_ch≥NUM_CH or wt_idx>25 are dropped, and wt_err pulses the next cycle.
  - Writes while frame_busy=1 are also dropped with wt_err, so weights stay stable across a frame.
  - A write in the same cycle as a sof pixel is dropped (the frame is treated as busy).
- Result holds its last value while result_valid=0.
- Reset mid-frame: everything returns to reset values immediately. No result_valid appears until a full new window is received.

Test Plan:
- Load all weights=1 and biases=0 for every channel, then stream a 28x28 frame of all-1 pixels → 576 results, every channel=25. First result_valid is 3 cycles after pixel (4,4). frame_done coincides with the 576th result.
- Channel 1 with center tap (wt_idx 12)=-1, bias=10, RELU_EN=1, pixels=20 → channel 1=0 (-10 clamped). Channel 1 with bias=30 → channel 1=10.
- Set OUT_SHIFT=2 and OUT_WIDTH=8, all weights=127, pixels=255 → the 809625 sum shifts to 202406 and saturates to 127.
- Drop valid_in on random cycles (about 50%) with the all-1 setup → still exactly 576 outputs of 25 and one frame_done.
- Write during frame_busy, write with wt_idx=26, and write with wt_ch=NUM_CH → wt_err pulses each time and the outputs are unchanged.
- Assert sof_in at pixel (10,3) mid-frame → no frame_done for the aborted frame. The next full 784 pixels give 576 outputs and one frame_done.

Source files
------------

// File: rtl/conv5x5_multich_stream.sv
// Streaming valid-mode 5x5 convolution over an unsigned pixel stream.
// NUM_CH output channels share one set of line buffers and one window.
// Each channel has its own runtime-loadable taps and bias.
// Pipeline: window -> 25 products/channel -> sum+bias+ReLU+shift+saturate.
// A pixel accepted in cycle T produces its result in cycle T+3.
module conv5x5_multich_stream #(
    parameter int IMG_WIDTH    = 28,
    parameter int IMG_HEIGHT   = 28,
    parameter int NUM_CH       = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACC_WIDTH    = 24,
    parameter int OUT_WIDTH    = 16,
    parameter int OUT_SHIFT    = 0,
    parameter int RELU_EN      = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           valid_in,
    input  logic                           sof_in,
    input  logic [DATA_WIDTH-1:0]          pixel_in,
    input  logic                           wt_we,
    input  logic [2:0]                     wt_ch,
    input  logic [4:0]                     wt_idx,
    input  logic [WEIGHT_WIDTH-1:0]        wt_data,
    output logic                           wt_err,
    output logic                           frame_busy,
    output logic [NUM_CH*OUT_WIDTH-1:0]    result,
    output logic                           result_valid,
    output logic                           frame_done
);

    localparam int CW   = $clog2(IMG_WIDTH);
    localparam int RW   = $clog2(IMG_HEIGHT);
    localparam int PW   = DATA_WIDTH + WEIGHT_WIDTH + 1;
    localparam int NTAP = 25;

    localparam logic [CW-1:0] COL_LAST      = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_FIRST_OUT = CW'(4);
    localparam logic [RW-1:0] ROW_FIRST_OUT = RW'(4);

    // ------------------------------------------------------------------
    // Position tracking
    // ------------------------------------------------------------------
    logic [CW-1:0] col_reg;
    logic [RW-1:0] row_reg;
    logic [CW-1:0] eff_col;
    logic [RW-1:0] eff_row;
    logic          col_last;
    logic          pix_last;
    logic          win_done;
    logic          frame_busy_reg;

    // Effective position of the incoming pixel; a start-of-frame forces (0,0).
    always_comb begin
        eff_col  = sof_in ? '0 : col_reg;
        eff_row  = sof_in ? '0 : row_reg;
        col_last = (eff_col == COL_LAST);
        pix_last = col_last && (eff_row == ROW_LAST);
        win_done = (eff_row >= ROW_FIRST_OUT) && (eff_col >= COL_FIRST_OUT);
    end

    // Advance the raster counters and the busy flag on every accepted pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_reg        <= '0;
            row_reg        <= '0;
            frame_busy_reg <= 1'b0;
        end else if (valid_in) begin
            frame_busy_reg <= !pix_last;
            if (pix_last) begin
                col_reg <= '0;
                row_reg <= '0;
            end else if (col_last) begin
                col_reg <= '0;
                row_reg <= eff_row + RW'(1);
            end else begin
                col_reg <= eff_col + CW'(1);
                row_reg <= eff_row;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line buffers: col_vec[k] is the pixel k rows above the current one
    // in the current column. The buffers cascade: each one hands its old
    // entry to the next as it takes the newer row. The read is
    // combinational so the window can load in the acceptance cycle.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] col_vec [0:4];

    assign col_vec[0] = pixel_in;

    for (genvar gi = 0; gi < 4; gi++) begin : gen_line
        logic [DATA_WIDTH-1:0] line_mem [0:IMG_WIDTH-1];

        // Store the newer row's pixel at this column on each accepted pixel.
        always_ff @(posedge clk) begin
            if (valid_in) begin
                line_mem[eff_col] <= col_vec[gi];
            end
        end

        assign col_vec[gi+1] = line_mem[eff_col];
    end

    // ------------------------------------------------------------------
    // 5x5 window; win_reg[i][j] is tap i*5+j, with row 0 the oldest row
    // and column 0 the leftmost column.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] win_reg [0:4][0:4];

    // Shift the window left and insert the new column on each accepted pixel.
    always_ff @(posedge clk) begin
        if (valid_in) begin
            for (int i = 0; i < 5; i++) begin
                for (int j = 0; j < 4; j++) begin
                    win_reg[i][j] <= win_reg[i][j+1];
                end
                win_reg[i][4] <= col_vec[4-i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Valid / last tracking through the three pipeline stages.
    // ------------------------------------------------------------------
    logic                        win_valid_reg;
    logic                        win_last_reg;
    logic                        prod_valid_reg;
    logic                        prod_last_reg;
    logic                        result_valid_reg;
    logic                        frame_done_reg;
    logic [NUM_CH*OUT_WIDTH-1:0] result_reg;
    logic [NUM_CH*OUT_WIDTH-1:0] res_next;

    // Carry the valid and end-of-frame flags alongside the data; results hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid_reg    <= 1'b0;
            win_last_reg     <= 1'b0;
            prod_valid_reg   <= 1'b0;
            prod_last_reg    <= 1'b0;
            result_valid_reg <= 1'b0;
            frame_done_reg   <= 1'b0;
            result_reg       <= '0;
        end else begin
            win_valid_reg    <= valid_in && win_done;
            win_last_reg     <= valid_in && pix_last;
            prod_valid_reg   <= win_valid_reg;
            prod_last_reg    <= win_valid_reg && win_last_reg;
            result_valid_reg <= prod_valid_reg;
            frame_done_reg   <= prod_valid_reg && prod_last_reg;
            if (prod_valid_reg) begin
                result_reg <= res_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Weight / bias write qualification. A sof pixel counts as busy, so a
    // write can never change the taps partway through a frame.
    // ------------------------------------------------------------------
    logic wr_ok;
    logic wt_err_reg;

    always_comb begin
        wr_ok = wt_we
             && ({1'b0, wt_ch} < 4'(NUM_CH))
             && (wt_idx <= 5'd25)
             && !frame_busy_reg
             && !(valid_in && sof_in);
    end

    // Flag any write that was not accepted, one cycle after the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wt_err_reg <= 1'b0;
        end else begin
            wt_err_reg <= wt_we && !wr_ok;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel weights, products and output arithmetic.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : gen_ch
        logic signed [WEIGHT_WIDTH-1:0] tap_reg [0:NTAP-1];
        logic signed [WEIGHT_WIDTH-1:0] bias_reg;
        logic signed [PW-1:0]           prod_reg [0:NTAP-1];
        logic signed [ACC_WIDTH-1:0]    acc_sum;
        logic signed [ACC_WIDTH-1:0]    acc_relu;
        logic signed [ACC_WIDTH-1:0]    acc_shift;
        logic [OUT_WIDTH-1:0]           ch_out;

        // Load one tap or the bias of this channel on an accepted write.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < NTAP; k++) begin
                    tap_reg[k] <= '0;
                end
                bias_reg <= '0;
            end else if (wr_ok && (wt_ch == 3'(gi))) begin
                for (int k = 0; k < NTAP; k++) begin
                    if (wt_idx == 5'(k)) begin
                        tap_reg[k] <= wt_data;
                    end
                end
                if (wt_idx == 5'd25) begin
                    bias_reg <= wt_data;
                end
            end
        end

        // Multiply every window pixel (zero-extended) by its signed tap.
        always_ff @(posedge clk) begin
            if (win_valid_reg) begin
                for (int k = 0; k < NTAP; k++) begin
                    prod_reg[k] <= PW'($signed({1'b0, win_reg[k/5][k%5]})) * PW'(tap_reg[k]);
                end
            end
        end

        // Sum products with the bias, then apply ReLU and the arithmetic shift.
        always_comb begin
            acc_sum = ACC_WIDTH'(bias_reg);
            for (int k = 0; k < NTAP; k++) begin
                acc_sum = acc_sum + ACC_WIDTH'(prod_reg[k]);
            end
            acc_relu  = ((RELU_EN != 0) && acc_sum[ACC_WIDTH-1]) ? '0 : acc_sum;
            acc_shift = acc_relu >>> OUT_SHIFT;
        end

        if (OUT_WIDTH < ACC_WIDTH) begin : gen_sat
            localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
            localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

            // Clamp when the dropped upper bits disagree with the sign bit.
            always_comb begin
                ch_out = acc_shift[OUT_WIDTH-1:0];
                if (!acc_shift[ACC_WIDTH-1] && (|acc_shift[ACC_WIDTH-2:OUT_WIDTH-1])) begin
                    ch_out = OUT_MAX;
                end else if (acc_shift[ACC_WIDTH-1] && !(&acc_shift[ACC_WIDTH-2:OUT_WIDTH-1])) begin
                    ch_out = OUT_MIN;
                end
            end
        end else begin : gen_ext
            assign ch_out = OUT_WIDTH'(acc_shift);
        end

        assign res_next[gi*OUT_WIDTH +: OUT_WIDTH] = ch_out;
    end

    assign wt_err       = wt_err_reg;
    assign frame_busy   = frame_busy_reg;
    assign result       = result_reg;
    assign result_valid = result_valid_reg;
    assign frame_done   = frame_done_reg;

endmodule
